if_hazard_ctrl: RTL
===================

# if_hazard_ctrl

Pipeline control unit that sequences the IF/ID pipeline register and the PC in the 5-stage core. It detects load-use hazards, branch mispredicts resolved in EX, and instruction-memory wait states. It drives the write-enable and flush of the IF/ID register, the PC write-enable and redirect, and the ID/EX bubble. It also keeps saturating stall and flush counters for performance debug.

## Interface
- DBITS, 32, PC/target width
- REGNO_BITS, 4, register-number width
- CNT_BITS, 16, performance counter width

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2  in  REGNO_BITS  ID source registers
- id_uses_rs1, id_uses_rs2  in  1  source actually read
- ex_is_load  in  1  EX instruction is a load
- ex_rd  in  REGNO_BITS  EX destination register
- br_resolve  in  1  EX resolved a branch or jump this cycle
- br_mispredict  in  1  resolved prediction was wrong (qualified by br_resolve)
- br_target  in  DBITS  correct next PC
- imem_ready  in  1  instruction word valid this cycle
- pc_wrt_en  out  1  PC register write enable
- IF_wrt_en  out  1  IF/ID register write enable
- IF_flush  out  1  load NOP/zero into IF/ID register (prediction field cleared)
- ID_bubble  out  1  insert bubble into ID/EX
- pc_redirect  out  1  PC mux selects pc_redirect_target
- pc_redirect_target  out  DBITS  equals br_target when pc_redirect=1, else 0
- stall_count, flush_count  out  CNT_BITS  saturating counters

## Operation
- States: RUN, LOAD_STALL, IMEM_WAIT. Control outputs are combinational from the state and the inputs. State and counters are registered.
- Hazard terms:
  - mp = br_resolve & br_mispredict.
  - lu = id_valid & ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - lu is ignored in LOAD_STALL.
- Priority: mp > lu > imem wait.
- mp, in any state:
  - Outputs: pc_redirect=1, pc_wrt_en=1, IF_wrt_en=1, IF_flush=1, ID_bubble=1.
  - flush_count +1.
  - Next state is IMEM_WAIT if imem_ready=0, else RUN.
- lu, in RUN:
  - Outputs: pc_wrt_en=0, IF_wrt_en=0, IF_flush=0, ID_bubble=1.
  - Next state LOAD_STALL.
- LOAD_STALL (no mp): normal advance. Next state is RUN, or IMEM_WAIT if imem_ready=0.
- imem_ready=0 (no mp, no lu):
  - Outputs: pc_wrt_en=0, IF_wrt_en=1, IF_flush=1 (NOP enters ID), ID_bubble=0.
  - State IMEM_WAIT. Stay there until imem_ready=1.
  - On imem_ready=1: normal advance, back to RUN.
- Normal advance: pc_wrt_en=1, IF_wrt_en=1, all other control outputs 0.
- stall_count +1 every cycle pc_wrt_en=0 while reset is deasserted. Both counters saturate at all-ones.

## Timing
- Hazard response has zero latency: the outputs react in the same cycle as the inputs.
- A load-use stall lasts exactly one cycle, even if lu remains true in the following cycle.
- Mispredict flush: the IF and ID wrong-path instructions are killed in the resolve cycle. The first correct-path fetch occurs in the next cycle.
- A mispredict coinciding with lu or an imem wait: mp wins. The counters record only the flush, plus a stall if pc_wrt_en=0 (never the case under mp).
- Reset (reset=0, sampled at the edge):
  - Next state RUN; both counters 0.
  - While reset=0, outputs are forced: pc_wrt_en=0, IF_wrt_en=1, IF_flush=1, ID_bubble=1, pc_redirect=0, pc_redirect_target=0.
  - Reset mid-stall or mid-wait abandons that state with no residual effect.

## Structure
- Shared package pipeline_ctrl_pkg:
  - state enum (RUN, LOAD_STALL, IMEM_WAIT);
  - REGNO_BITS default;
  - ZERO_REG constant (0).
- One sub-module, sat_counter (CNT_BITS, synchronous active-low clear, inc), instantiated twice.

## Test plan
- Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 → one cycle with pc_wrt_en=0, IF_wrt_en=0, ID_bubble=1. Next cycle normal advance with lu still high. stall_count=1.
- ex_rd=0 matching id_rs1=0 → no stall.
- Mispredict: br_resolve=1, br_mispredict=1, br_target=0x40 → pc_redirect=1, target 0x40, IF_flush=1, ID_bubble=1. flush_count=1.
- Mispredict and lu in the same cycle → redirect behaviour only, no stall. stall_count unchanged.
- imem_ready low for 3 cycles → 3 cycles of pc_wrt_en=0, IF_flush=1, then RUN. stall_count=3.
- reset=0 asserted in IMEM_WAIT with counters at 7/2 → next cycle state RUN, counters 0, forced reset outputs. With counters preloaded to all-ones, another stall leaves stall_count at all-ones.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline control slice.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_IMEM_WAIT  = 2'd2
  } state_e;

  localparam int REGNO_BITS_DEF = 4;

  // Register x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int CNT_BITS = 16
) (
  input  logic                i_clk,
  input  logic                i_clr_b,
  input  logic                i_inc,
  output logic [CNT_BITS-1:0] o_count
);

  logic [CNT_BITS-1:0] r_count;

  // Clear dominates; otherwise count up and hold at all-ones.
  always_ff @(posedge i_clk) begin
    if (!i_clr_b) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_BITS{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/if_hazard_ctrl.sv
// IF/ID and PC sequencing: load-use stall, mispredict flush, imem wait states.
//
// state         | meaning
// --------------+----------------------------------------------------------
// ST_RUN        | normal fetch/advance
// ST_LOAD_STALL | a one-cycle load-use stall was just taken; lu is ignored
// ST_IMEM_WAIT  | instruction memory not ready; PC held, NOPs fed to ID
module if_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DBITS      = 32,
  parameter int REGNO_BITS = REGNO_BITS_DEF,
  parameter int CNT_BITS   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_id_valid,
  input  logic [REGNO_BITS-1:0] i_id_rs1,
  input  logic [REGNO_BITS-1:0] i_id_rs2,
  input  logic                  i_id_uses_rs1,
  input  logic                  i_id_uses_rs2,
  input  logic                  i_ex_is_load,
  input  logic [REGNO_BITS-1:0] i_ex_rd,
  input  logic                  i_br_resolve,
  input  logic                  i_br_mispredict,
  input  logic [DBITS-1:0]      i_br_target,
  input  logic                  i_imem_ready,
  output logic                  o_pc_wrt_en,
  output logic                  o_IF_wrt_en,
  output logic                  o_IF_flush,
  output logic                  o_ID_bubble,
  output logic                  o_pc_redirect,
  output logic [DBITS-1:0]      o_pc_redirect_target,
  output logic [CNT_BITS-1:0]   o_stall_count,
  output logic [CNT_BITS-1:0]   o_flush_count
);

  state_e r_state;
  state_e w_next_state;
  logic   w_mp;
  logic   w_lu;
  logic   w_lu_act;
  logic   w_rs1_hit;
  logic   w_rs2_hit;

  assign w_mp      = i_br_resolve & i_br_mispredict;
  assign w_rs1_hit = i_id_uses_rs1 & (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit = i_id_uses_rs2 & (i_id_rs2 == i_ex_rd);
  assign w_lu      = i_id_valid & i_ex_is_load
                   & (i_ex_rd != REGNO_BITS'(ZERO_REG))
                   & (w_rs1_hit | w_rs2_hit);
  // The stall is one cycle only: a lingering match right after the stall is the
  // same dependence, now satisfied by forwarding.
  assign w_lu_act  = w_lu & (r_state != ST_LOAD_STALL);

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection in priority order: mispredict, load-use, imem wait.
  always_comb begin
    w_next_state = r_state;
    if (w_mp) begin
      w_next_state = i_imem_ready ? ST_RUN : ST_IMEM_WAIT;
    end else if (w_lu_act) begin
      w_next_state = ST_LOAD_STALL;
    end else if (!i_imem_ready) begin
      w_next_state = ST_IMEM_WAIT;
    end else begin
      w_next_state = ST_RUN;
    end
  end

  // Zero-latency control outputs; reset forces a bubble/NOP with the PC held.
  always_comb begin
    o_pc_wrt_en          = 1'b0;
    o_IF_wrt_en          = 1'b0;
    o_IF_flush           = 1'b0;
    o_ID_bubble          = 1'b0;
    o_pc_redirect        = 1'b0;
    o_pc_redirect_target = '0;
    if (!i_reset) begin
      o_IF_wrt_en = 1'b1;
      o_IF_flush  = 1'b1;
      o_ID_bubble = 1'b1;
    end else if (w_mp) begin
      o_pc_wrt_en          = 1'b1;
      o_IF_wrt_en          = 1'b1;
      o_IF_flush           = 1'b1;
      o_ID_bubble          = 1'b1;
      o_pc_redirect        = 1'b1;
      o_pc_redirect_target = i_br_target;
    end else if (w_lu_act) begin
      o_ID_bubble = 1'b1;
    end else if (!i_imem_ready) begin
      // No valid fetch word: hold the PC and let a NOP enter ID.
      o_IF_wrt_en = 1'b1;
      o_IF_flush  = 1'b1;
    end else begin
      o_pc_wrt_en = 1'b1;
      o_IF_wrt_en = 1'b1;
    end
  end

  sat_counter #(.CNT_BITS(CNT_BITS)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_clr_b (i_reset),
    .i_inc   (~o_pc_wrt_en),
    .o_count (o_stall_count)
  );

  sat_counter #(.CNT_BITS(CNT_BITS)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_clr_b (i_reset),
    .i_inc   (o_pc_redirect),
    .o_count (o_flush_count)
  );

endmodule
